// File: rtl/instr_prefetch_queue_pkg.sv
// Shared ISA field geometry and queue defaults for the instruction prefetch path.
// The decode stage imports the same constants, so both stages split a word the same way.
package instr_prefetch_queue_pkg;

   localparam int DEF_WORD_WIDTH    = 16;
   localparam int DEF_OPCODE_WIDTH  = 7;
   localparam int DEF_OPERAND_WIDTH = 3;
   localparam int DEF_DEPTH         = 4;
   localparam int DEF_IMM_FLAG_BIT  = 6;

   // Position of the two-word flag inside a full instruction word.
   function automatic int imm_flag_pos(input int word_width, input int opcode_width,
                                       input int imm_flag_bit);
      return word_width - opcode_width + imm_flag_bit;
   endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction prefetch queue.
// The fetch/decode stages use the master modport; the queue uses the slave modport.
interface instr_prefetch_queue_if
   import instr_prefetch_queue_pkg::*;
#(
   parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
   parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH,
   parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WORD_WIDTH-1:0]    in_word;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [OPCODE_WIDTH-1:0]  out_opcode;
   logic [OPERAND_WIDTH-1:0] out_op0;
   logic [OPERAND_WIDTH-1:0] out_op1;
   logic [OPERAND_WIDTH-1:0] out_op2;
   logic [WORD_WIDTH-1:0]    out_imm;
   logic                     out_long;

   modport master (
      output in_valid, in_word, flush, out_ready,
      input  in_ready, out_valid, out_opcode, out_op0, out_op1, out_op2, out_imm, out_long
   );

   modport slave (
      input  in_valid, in_word, flush, out_ready,
      output in_ready, out_valid, out_opcode, out_op0, out_op1, out_op2, out_imm, out_long
   );
endinterface

// File: rtl/instr_queue_mem.sv
// DEPTH x WORD_WIDTH register file holding queued instruction words.
// It has one write port and two asynchronous read ports (head and head+1, wrapping).
module instr_queue_mem
   import instr_prefetch_queue_pkg::*;
#(
   parameter int  WORD_WIDTH = DEF_WORD_WIDTH,
   parameter int  DEPTH      = DEF_DEPTH,
   localparam int AW         = $clog2(DEPTH)
)(
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [WORD_WIDTH-1:0] head,
   output logic [WORD_WIDTH-1:0] next
);
   logic [WORD_WIDTH-1:0] storage [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         storage[wr_addr] <= wr_data;
      end
   end

   // Power-of-two depth lets the address wrap naturally. This allows an immediate to straddle the end of the queue.
   assign head = storage[rd_addr];
   assign next = storage[rd_addr + AW'(1)];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Prefetch queue between fetch and decode. It splits the head word into fields.
// It holds back two-word instructions until their immediate word has also arrived.
module instr_prefetch_queue
   import instr_prefetch_queue_pkg::*;
#(
   parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
   parameter int OPCODE_WIDTH  = DEF_OPCODE_WIDTH,
   parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
   parameter int DEPTH         = DEF_DEPTH,
   parameter int IMM_FLAG_BIT  = DEF_IMM_FLAG_BIT
)(
   input  logic                    clock,
   input  logic                    not_reset,
   instr_prefetch_queue_if.slave   bus
);
   localparam int AW       = $clog2(DEPTH);
   localparam int CW       = $clog2(DEPTH + 1);
   localparam int FLAG_POS = imm_flag_pos(WORD_WIDTH, OPCODE_WIDTH, IMM_FLAG_BIT);

   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         pop_cnt;
   logic [WORD_WIDTH-1:0] head_word;
   logic [WORD_WIDTH-1:0] next_word;
   logic                  has_one;
   logic                  has_two;
   logic                  is_long;
   logic                  push;
   logic                  pop;

   instr_queue_mem #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clock   (clock),
      .wr_en   (push && !bus.flush),
      .wr_addr (wr_ptr),
      .wr_data (bus.in_word),
      .rd_addr (rd_ptr),
      .head    (head_word),
      .next    (next_word)
   );

   // Gate with not_reset so the outputs are quiet during reset, before the count register is cleared.
   assign has_one = not_reset && (count != '0);
   assign has_two = not_reset && (count > CW'(1));
   assign is_long = has_one && head_word[FLAG_POS];

   assign bus.in_ready   = not_reset && (count != CW'(DEPTH));
   assign bus.out_long   = is_long;
   assign bus.out_valid  = is_long ? has_two : has_one;
   assign bus.out_opcode = head_word[WORD_WIDTH-1 -: OPCODE_WIDTH];
   assign bus.out_op0    = head_word[3*OPERAND_WIDTH-1 -: OPERAND_WIDTH];
   assign bus.out_op1    = head_word[2*OPERAND_WIDTH-1 -: OPERAND_WIDTH];
   assign bus.out_op2    = head_word[OPERAND_WIDTH-1:0];
   assign bus.out_imm    = is_long ? next_word : '0;

   assign push    = bus.in_valid && bus.in_ready;
   assign pop     = bus.out_valid && bus.out_ready;
   assign pop_cnt = !pop ? '0 : (is_long ? CW'(2) : CW'(1));

   always_ff @(posedge clock) begin
      if (!not_reset || bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(pop_cnt);
         wr_ptr <= wr_ptr + AW'(push);
         count  <= count + CW'(push) - pop_cnt;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomised plus directed bench for instr_prefetch_queue.
// A word-queue reference model predicts the head instruction; a scoreboard checks each consumed instruction.
module tb_instr_prefetch_queue;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  o0;
      logic [2:0]  o1;
      logic [2:0]  o2;
      logic [15:0] imm;
      bit          lng;
   } instr_t;

   logic clock;
   logic not_reset;

   instr_prefetch_queue_if bus ();

   instr_prefetch_queue dut (
      .clock     (clock),
      .not_reset (not_reset),
      .bus       (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] model_q [$];
   instr_t      sb [$];

   bit     armed = 0;
   bit     exp_valid;
   bit     exp_ready;
   bit     exp_long;
   instr_t exp_head;

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // The model splits the head word arithmetically.
   function automatic instr_t head_of();
      instr_t h;
      int     w;
      w     = int'(model_q[0]);
      h.opc = 7'(w / 512);
      h.o0  = 3'((w / 64) % 8);
      h.o1  = 3'((w / 8) % 8);
      h.o2  = 3'(w % 8);
      h.lng = ((h.opc / 64) % 2) == 1;
      h.imm = (h.lng && model_q.size() >= 2) ? model_q[1] : 16'h0;
      return h;
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w     = 16'($urandom);
      w[15] = ($urandom_range(0, 9) < 4);
      return w;
   endfunction

   task automatic drive(input bit rst_n, input bit iv, input logic [15:0] w,
                        input bit fl, input bit ordy);
      instr_t h;
      bit     hv;
      @(negedge clock);
      not_reset     = rst_n;
      bus.in_valid  = iv;
      bus.in_word   = w;
      bus.flush     = fl;
      bus.out_ready = ordy;
      h  = '{default: 0};
      hv = 0;
      if (rst_n && model_q.size() >= 1) begin
         h  = head_of();
         hv = h.lng ? (model_q.size() >= 2) : 1'b1;
      end
      exp_head  = h;
      exp_valid = hv;
      exp_long  = rst_n && model_q.size() >= 1 && h.lng;
      exp_ready = rst_n && model_q.size() < 4;
      armed     = 1;
      if (!rst_n || fl) begin
         model_q.delete();
      end else begin
         if (hv && ordy) begin
            sb.push_back(h);
            repeat (h.lng ? 2 : 1) void'(model_q.pop_front());
         end
         if (iv && exp_ready) model_q.push_back(w);
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) drive(1, 0, 16'h0, 0, ordy);
   endtask

   // Monitor: checks the presented head against the model every cycle, and checks each consumed instruction against the scoreboard.
   initial begin
      instr_t e;
      forever begin
         @(negedge clock);
         #2;
         if (armed) begin
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("out_long", 32'(bus.out_long), 32'(exp_long));
            if (exp_valid) begin
               chk("head_opcode", 32'(bus.out_opcode), 32'(exp_head.opc));
               chk("head_op0", 32'(bus.out_op0), 32'(exp_head.o0));
               chk("head_op1", 32'(bus.out_op1), 32'(exp_head.o1));
               chk("head_op2", 32'(bus.out_op2), 32'(exp_head.o2));
               chk("head_imm", 32'(bus.out_imm), 32'(exp_head.imm));
            end else if (!exp_long) begin
               chk("idle_imm", 32'(bus.out_imm), 32'h0);
            end
            if (bus.out_valid && bus.out_ready && !bus.flush && not_reset) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop_unexpected: got consume of opcode 0x%0h expected no instruction", bus.out_opcode);
               end else begin
                  e = sb.pop_front();
                  chk("pop_opcode", 32'(bus.out_opcode), 32'(e.opc));
                  chk("pop_ops", {23'h0, bus.out_op0, bus.out_op1, bus.out_op2}, {23'h0, e.o0, e.o1, e.o2});
                  chk("pop_imm", 32'(bus.out_imm), 32'(e.imm));
                  chk("pop_long", 32'(bus.out_long), 32'(e.lng));
               end
            end
         end
      end
   end

   logic [15:0] stream [12] = '{16'h0E53, 16'h1111, 16'h2222, 16'h8123, 16'hBEEF, 16'h3333,
                                16'hC001, 16'h0042, 16'h4444, 16'h5555, 16'hE0E0, 16'h1234};

   initial begin
      not_reset     = 0;
      bus.in_valid  = 0;
      bus.in_word   = '0;
      bus.flush     = 0;
      bus.out_ready = 0;

      // Reset held with the fetch side still presenting a word
      drive(0, 1, 16'hAAAA, 0, 0);
      drive(0, 1, 16'hAAAA, 0, 0);
      idle(1, 0);

      // Short instruction
      drive(1, 1, 16'h0E53, 0, 0);
      drive(1, 0, 16'h0, 0, 1);
      idle(1, 1);

      // Long instruction: a lone first word stays invisible
      drive(1, 1, 16'h8000, 0, 1);
      idle(3, 1);
      drive(1, 1, 16'hBEEF, 0, 1);
      idle(2, 1);

      // Fill to capacity, then try a fifth word
      for (int i = 0; i < 5; i++) drive(1, 1, 16'(16'h0100 * (i + 1)), 0, 0);
      idle(5, 1);

      // Streaming from zeroed pointers; the long word at 0x8123 lands at index 3 so its immediate wraps to 0
      drive(1, 0, 16'h0, 1, 0);
      for (int i = 0; i < 12; i++) drive(1, 1, stream[i], 0, 1);
      idle(4, 1);

      // Flush together with push and pop
      for (int i = 0; i < 3; i++) drive(1, 1, 16'(16'h0A00 + i), 0, 0);
      drive(1, 1, 16'h7777, 1, 1);
      idle(2, 1);

      // Stall while the fetch side keeps pushing
      drive(1, 1, 16'h8456, 0, 0);
      drive(1, 1, 16'h9ABC, 0, 0);
      for (int i = 0; i < 5; i++) drive(1, 1, rand_word(), 0, 0);
      idle(6, 1);

      // Random traffic including occasional flush and reset
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, rand_word(),
               $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
      end

      drive(1, 0, 16'h0, 1, 0);
      idle(3, 1);
      @(negedge clock);
      #3;
      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
